// File: rtl/alu_16.sv
// ---------------------------------------------------------------------------
// alu_16 : 16-bit two's-complement ALU for the execute stage.
//
// The datapath (alu_out, z, v, n) is purely combinational with zero latency.
// A small clocked status register captures {z, v, n} when flag_we is high,
// so later conditional branches can test the flags.
//
// Optional feature (macro ALU16_SAT_EN):
//   defined   - ADD/SUB saturate on signed overflow (0x7FFF / 0x8000);
//               v still reports the overflow, z/n follow the saturated value.
//   undefined - ADD/SUB wrap modulo 2^16 (default).
//
// Ports:
//   alu_op  [2:0]  operation select (`ALU_* codes below)
//   alu_a   [15:0] operand A
//   alu_b   [15:0] operand B (b[3:0] is the shift amount for SHL/SHR)
//   alu_out [15:0] result (combinational)
//   z, v, n        zero / signed overflow / negative flags (combinational)
//   clk            clock, status register updates on the rising edge
//   rst            synchronous active-high reset of the status register
//   flag_we        load {z, v, n} into the status register at the next edge
//   sr_z/sr_v/sr_n registered flags
// ---------------------------------------------------------------------------
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_NOT 3'd5
`define ALU_SHL 3'd6
`define ALU_SHR 3'd7
`endif

module alu_16 #(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             z,
  output logic             v,
  output logic             n,
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_we,
  output logic             sr_z,
  output logic             sr_v,
  output logic             sr_n
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] raw;   // wrap-around result before optional saturation
  logic             ovf;   // signed overflow of ADD/SUB
  logic [3:0]       shamt;

  assign shamt = alu_b[3:0];

  always_comb begin
    raw = '0;
    ovf = 1'b0;
    case (alu_op)
      `ALU_ADD: begin
        raw = alu_a + alu_b;
        // Same-sign operands producing a result of the other sign.
        ovf = (alu_a[MSB] == alu_b[MSB]) && (raw[MSB] != alu_a[MSB]);
      end
      `ALU_SUB: begin
        raw = alu_a - alu_b;
        // Opposite-sign operands and the result's sign departs from A.
        ovf = (alu_a[MSB] != alu_b[MSB]) && (raw[MSB] != alu_a[MSB]);
      end
      `ALU_AND: raw = alu_a & alu_b;
      `ALU_OR:  raw = alu_a | alu_b;
      `ALU_XOR: raw = alu_a ^ alu_b;
      `ALU_NOT: raw = ~alu_a;
      `ALU_SHL: raw = alu_a << shamt;
      `ALU_SHR: raw = alu_a >> shamt;
      default:  raw = '0;
    endcase
  end

`ifdef ALU16_SAT_EN
  // On overflow the true result lies beyond the range on A's side:
  // positive A overflows upward, negative A overflows downward.
  always_comb begin
    alu_out = raw;
    if (ovf) begin
      alu_out = alu_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign alu_out = raw;
`endif

  assign z = (alu_out == '0);
  assign v = ovf;
  assign n = alu_out[MSB];

  // Status register: reset wins over a flag load.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_z <= 1'b0;
      sr_v <= 1'b0;
      sr_n <= 1'b0;
    end else if (flag_we) begin
      sr_z <= z;
      sr_v <= v;
      sr_n <= n;
    end
  end

endmodule

// File: tb/tb_alu_16.sv
// ---------------------------------------------------------------------------
// tb_alu_16 : self-checking bench for alu_16.
// Directed vectors use hand-derived constants; random vectors are checked
// against an integer-arithmetic reference model. Flags are also tracked
// through a model of the status register.
// ---------------------------------------------------------------------------
module tb_alu_16;

  localparam int W = 19;  // {out[15:0], z, v, n}

  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [15:0] alu_out;
  logic        z, v, n;
  logic        clk;
  logic        rst;
  logic        flag_we;
  logic        sr_z, sr_v, sr_n;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [2:0]   last_flags;  // expected {z, v, n} for the inputs now applied
  logic [2:0]   sr_exp;      // expected status register contents

  alu_16 dut (
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_out (alu_out),
    .z       (z),
    .v       (v),
    .n       (n),
    .clk     (clk),
    .rst     (rst),
    .flag_we (flag_we),
    .sr_z    (sr_z),
    .sr_v    (sr_v),
    .sr_n    (sr_n)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer arithmetic on signed/unsigned values.
  function automatic logic [W-1:0] model(input logic [2:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    longint sa, sb, r, ua, p;
    logic [15:0] o;
    logic        ov;
    sa = a[15] ? longint'(a) - 65536 : longint'(a);
    sb = b[15] ? longint'(b) - 65536 : longint'(b);
    ua = longint'(a);
    p  = longint'(1) << b[3:0];
    ov = 1'b0;
    o  = 16'h0;
    r  = 0;
    case (op)
      3'd0, 3'd1: begin
        r  = (op == 3'd0) ? sa + sb : sa - sb;
        ov = (r > 32767) || (r < -32768);
        o  = 16'((r % 65536 + 65536) % 65536);
`ifdef ALU16_SAT_EN
        if (ov) o = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: o = 16'(65535 - ua);
      3'd6: o = 16'((ua * p) % 65536);
      default: o = 16'(ua / p);
    endcase
    return {o, (o == 16'h0), ov, (o >= 16'h8000)};
  endfunction

  // Scoreboard compare of the combinational outputs against the queue head.
  task automatic compare_head(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    last_flags = e[2:0];
    checks++;
    assert (alu_out === e[18:3]) else begin
      errors++;
      $error("FAIL %s out: got %h expected %h", tag, alu_out, e[18:3]);
    end
    checks++;
    assert (z === e[2]) else begin
      errors++;
      $error("FAIL %s z: got %b expected %b", tag, z, e[2]);
    end
    checks++;
    assert (v === e[1]) else begin
      errors++;
      $error("FAIL %s v: got %b expected %b", tag, v, e[1]);
    end
    checks++;
    assert (n === e[0]) else begin
      errors++;
      $error("FAIL %s n: got %b expected %b", tag, n, e[0]);
    end
  endtask

  // Driver: apply operands away from the rising edge, then check.
  task automatic drive(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b);
    @(negedge clk);
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] eo, input logic ez,
                           input logic ev, input logic en);
    drive(op, a, b);
    exp_q.push_back({eo, ez, ev, en});
    compare_head(tag);
  endtask

  task automatic check_rand(input logic [2:0] op, input logic [15:0] a,
                            input logic [15:0] b);
    drive(op, a, b);
    exp_q.push_back(model(op, a, b));
    compare_head($sformatf("rand op%0d %h,%h", op, a, b));
  endtask

  // One rising edge with the given control inputs, then check the status reg.
  task automatic edge_step(input string tag, input logic we, input logic r);
    flag_we = we;
    rst     = r;
    @(posedge clk);
    #1;
    if (r)       sr_exp = 3'b000;
    else if (we) sr_exp = last_flags;
    checks++;
    assert ({sr_z, sr_v, sr_n} === sr_exp) else begin
      errors++;
      $error("FAIL %s sr: got %b%b%b expected %b", tag, sr_z, sr_v, sr_n,
             sr_exp);
    end
    flag_we = 1'b0;
    rst     = 1'b0;
  endtask

  initial begin
    alu_op = 3'd0; alu_a = 16'h0; alu_b = 16'h0;
    flag_we = 1'b0; rst = 1'b1;
    last_flags = 3'b000; sr_exp = 3'b000;

    // Reset state of the status register.
    @(negedge clk);
    edge_step("reset", 1'b0, 1'b1);

    // Reset has no effect on the combinational path.
    drive(3'd0, 16'h0001, 16'h0001);
    rst = 1'b1;
    #1;
    exp_q.push_back({16'h0002, 1'b0, 1'b0, 1'b0});
    compare_head("add_during_rst");
    rst = 1'b0;

    // Directed vectors.
    check_vec("add_1_1",        3'd0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0);
    check_vec("add_ffff_ffff",  3'd0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 0, 0, 1);
    check_vec("add_ffff_1",     3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0);
    check_vec("sub_8000_1",     3'd1, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0);
    check_vec("sub_1_2",        3'd1, 16'h0001, 16'h0002, 16'hFFFF, 0, 0, 1);
    check_vec("and",            3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0);
    check_vec("or",             3'd3, 16'h8001, 16'h0100, 16'h8101, 0, 0, 1);
    check_vec("xor_a5a5",       3'd4, 16'hA5A5, 16'hFFFF, 16'h5A5A, 0, 0, 0);
    check_vec("not_ffff",       3'd5, 16'hFFFF, 16'h1234, 16'h0000, 1, 0, 0);
    check_vec("shl_1_15",       3'd6, 16'h0001, 16'h000F, 16'h8000, 0, 0, 1);
    check_vec("shl_ignore_hi",  3'd6, 16'h00FF, 16'hFFF4, 16'h0FF0, 0, 0, 0);
    check_vec("shr_by_0",       3'd7, 16'h8421, 16'h0000, 16'h8421, 0, 0, 1);
    check_vec("shr_8000_15",    3'd7, 16'h8000, 16'h001F, 16'h0001, 0, 0, 0);

    // Capture flags of 0x7FFF+1, hold, then reset with flag_we also high.
    check_vec("add_7fff_1",     3'd0, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 1);
    edge_step("sr_load", 1'b1, 1'b0);
    check_vec("add_ffff_1_b",   3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0);
    edge_step("sr_hold", 1'b0, 1'b0);
    edge_step("sr_rst_prio", 1'b1, 1'b1);
    edge_step("sr_load_z", 1'b1, 1'b0);

    // Random stimulus, biased toward sign-boundary operands.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = {a[15], {15{~a[15]}}};
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 2));
      check_rand(3'($urandom_range(0, 7)), a, b);
      if ($urandom_range(0, 2) == 0)
        edge_step("sr_rand", 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
